// File: rtl/decoder24_pkg.sv
// Shared types and helpers for the sequential 2-to-4 decoder.
package decoder24_pkg;

  localparam int unsigned N_LINES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam logic [1:0] CODE_Y0 = 2'b11;
  localparam logic [1:0] CODE_Y1 = 2'b01;
  localparam logic [1:0] CODE_Y2 = 2'b10;
  localparam logic [1:0] CODE_Y3 = 2'b00;

  // Map an input code to its one-hot output line.
  function automatic logic [3:0] code_to_onehot(input logic [1:0] code);
    logic [3:0] oh;
    oh = 4'b0000;
    case (code)
      CODE_Y0: oh = 4'b0001;
      CODE_Y1: oh = 4'b0010;
      CODE_Y2: oh = 4'b0100;
      CODE_Y3: oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/decoder24_hold_sat_cnt.sv
// Saturating event counter; clear takes priority over increment.
module sat_cnt #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc_i,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/decoder24_hold.sv
// Sequential 2-to-4 decoder: buffered valid/ready input, one-hot strobe held
// for HOLD cycles followed by a GAP-cycle idle, with per-line event counters.
module decoder24_hold
  import decoder24_pkg::*;
#(
  parameter int unsigned HOLD = 4,
  parameter int unsigned GAP  = 1,
  parameter int unsigned CW   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    a,
  input  logic          a_valid,
  output logic          a_ready,
  output logic [3:0]    y,
  output logic          busy,
  input  logic [1:0]    cnt_sel,
  input  logic          cnt_clr,
  output logic [CW-1:0] cnt_out
);

  localparam int unsigned HG_MAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int unsigned TW     = $clog2(HG_MAX + 1);
  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD - 1);
  localparam logic [TW-1:0] GAP_LD  = (GAP > 0) ? TW'(GAP - 1) : '0;

  state_e      state_q, state_d;
  logic [TW-1:0] ctr_q, ctr_d;
  logic [1:0]  active_q, active_d;
  logic [1:0]  buf_q, buf_d;
  logic        full_q, full_d;
  logic [3:0]  y_q, y_d;
  logic        busy_q, busy_d;
  logic        load;
  logic        xfer;

  // load never looks at a_valid, so a_ready has no combinational input path.
  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q;
    active_d = active_q;
    load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (full_q) begin
          load    = 1'b1;
          state_d = ST_HOLD;
          ctr_d   = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (ctr_q != '0) begin
          ctr_d = ctr_q - TW'(1);
        end else if (GAP > 0) begin
          state_d = ST_GAP;
          ctr_d   = GAP_LD;
        end else if (full_q) begin
          load  = 1'b1;
          ctr_d = HOLD_LD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (ctr_q != '0) begin
          ctr_d = ctr_q - TW'(1);
        end else if (full_q) begin
          load    = 1'b1;
          state_d = ST_HOLD;
          ctr_d   = HOLD_LD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ctr_d   = '0;
      end
    endcase
    if (load) begin
      active_d = buf_q;
    end

    a_ready = !full_q || load;
    xfer    = a_valid && a_ready;
    full_d  = full_q;
    buf_d   = buf_q;
    if (xfer) begin
      full_d = 1'b1;
      buf_d  = a;
    end else if (load) begin
      full_d = 1'b0;
    end

    y_d    = (state_d == ST_HOLD) ? code_to_onehot(active_d) : 4'b0000;
    busy_d = (state_d != ST_IDLE) || full_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ctr_q    <= '0;
      active_q <= '0;
      buf_q    <= '0;
      full_q   <= 1'b0;
      y_q      <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      active_q <= active_d;
      buf_q    <= buf_d;
      full_q   <= full_d;
      y_q      <= y_d;
      busy_q   <= busy_d;
    end
  end

  assign y    = y_q;
  assign busy = busy_q;

  // One counter per output line, bumped by the line of the code being loaded.
  logic [3:0]    inc_w;
  logic [CW-1:0] cnt_w [N_LINES];

  assign inc_w = load ? code_to_onehot(buf_q) : 4'b0000;

  for (genvar i = 0; i < N_LINES; i++) begin : g_cnt
    sat_cnt #(.CW(CW)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (inc_w[i]),
      .clr_i (cnt_clr),
      .cnt_o (cnt_w[i])
    );
  end

  assign cnt_out = cnt_w[cnt_sel];

endmodule

// File: doc/decoder24_hold.md
# decoder24_hold

Sequential 2-to-4 decoder, the receive-side counterpart of the team's 4-to-2 encoder. It accepts 2-bit codes over a valid/ready handshake and drives the matching one-hot line on `y` for a programmable number of cycles, followed by a programmable idle gap. It keeps one code in an input buffer and a saturating event count per output line. It sits at the consumer end of an encoded select bus and drives strobes or selects that need a guaranteed minimum width.

## Interface
- `HOLD`, default 4: cycles each one-hot strobe stays asserted; legal range ≥1.
- `GAP`, default 1: cycles `y` is forced to 0 after each strobe; legal range ≥0.
- `CW`, default 8: width of each per-line event counter.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `a`  in  2: input code.
- `a_valid`  in  1: `a` is valid this cycle.
- `a_ready`  out  1: block can accept `a` this cycle.
- `y`  out  4: one-hot decoded strobe, or 0 when idle.
- `busy`  out  1: a strobe or gap is in progress, or a code is buffered.
- `cnt_sel`  in  2: selects which line's counter appears on `cnt_out`.
- `cnt_clr`  in  1: synchronous clear of all counters.
- `cnt_out`  out  CW: count for the line selected by `cnt_sel`; combinational read.

## Operation
- Code mapping:
  - `a`=2'b11 → `y`=4'b0001
  - `a`=2'b01 → `y`=4'b0010
  - `a`=2'b10 → `y`=4'b0100
  - `a`=2'b00 → `y`=4'b1000
- Handshake:
  - A transfer occurs on a rising edge where `a_valid` and `a_ready` are both 1.
  - `a_valid` may drop without a transfer; the block does not require it to be held.
- Input buffer:
  - One entry, holding the code plus a full flag.
  - `a_ready` = !full | load.
  - `load` is true when the FSM takes the buffered code at this edge. It depends only on the FSM state, the hold/gap counter and the full flag, never on `a_valid`.
  - A fill and a drain at the same edge are legal; the buffer stays full with the new code.
- FSM states:
  - IDLE: `y`=0. If the buffer is full, `load` occurs, the active register takes the buffered code and the state goes to HOLD with the counter at HOLD-1.
  - HOLD: `y` = one-hot of the active code. The counter decrements each cycle. When it reaches 0:
    - if GAP>0, go to GAP with the counter at GAP-1;
    - otherwise, if the buffer is full, `load` occurs and the state stays in HOLD back-to-back;
    - otherwise go to IDLE.
  - GAP: `y`=0. The counter decrements each cycle. When it reaches 0, `load` if the buffer is full (go to HOLD), otherwise go to IDLE.
- Counters:
  - The selected line's counter increments by 1 at each `load` edge, saturating at 2^CW-1.
  - `cnt_clr` clears all counters at the next edge. If a clear and an increment coincide, the clear wins.
- `busy` = (state != IDLE) | full.

## Timing
- Reset values: `y`=0, `a_ready`=1, `busy`=0, all counters 0, state IDLE, buffer empty.
- Latency with the block idle: a code transferred at edge k is loaded at edge k+1. `y` is asserted from edge k+1 to edge k+1+HOLD.
- Each strobe is exactly HOLD cycles wide. Each gap is exactly GAP cycles long.
- With `a_valid` held at 1, throughput is one code per HOLD+GAP cycles, with no extra bubble.
- `a_ready` is low only while the buffer is full and no `load` occurs in that cycle.
- Reset asserted mid-operation:
  - all state clears immediately and asynchronously;
  - the buffered and active codes are discarded;
  - `y` drops to 0 without waiting for the hold count to finish.
- `cnt_out` follows `cnt_sel` in the same cycle. Counter updates appear on `cnt_out` one edge after the `load` or clear edge that caused them.

## Structure
- Package `decoder24_pkg` holds:
  - the FSM state enum (IDLE, HOLD, GAP);
  - the four code constants;
  - a code-to-one-hot function, shared with encoder benches.
- Sub-module `sat_cnt`: a CW-bit saturating counter with inc and clr inputs, where clr has priority. It is instantiated four times.
- The hold/gap counter is a single down-counter of width $clog2(max(HOLD,GAP)+1), shared between the HOLD and GAP states.

## Test plan
- Reset, then one transfer of `a`=2'b01 with HOLD=4, GAP=1 → `y`=4'b0010 for exactly 4 cycles starting one edge after the transfer, 1 cycle at 0, then `busy`=0 and `cnt_out`(sel=1)=1.
- Back-to-back stream 11,10,00 with `a_valid` held at 1 → `y` sequence 0001, 0100, 1000, each 4 cycles wide with 1-cycle gaps, and `a_ready` low while the buffer is held.
- GAP=0 with two queued codes → the two strobes are contiguous and `y` never shows 0 between them.
- 300 transfers of code 2'b11 with CW=8 → line-0 counter saturates at 255. Then `cnt_clr` asserted on the same edge as a `load` → the counter reads 0.
- `rst_n` pulsed low during HOLD with a code buffered → `y`=0 and `a_ready`=1 immediately, and no strobe follows after reset is released.
- `a_valid` pulsed for one cycle while `a_ready`=0 → no transfer occurs and the counters are unchanged.
